commit_trace_packer: RTL and testbench
======================================

Name: commit_trace_packer

Overview:
Source end of the commit-trace interface. Samples the processor's per-cycle commit signals and classifies each commit into a typed record. Each record is stamped with an instruction number and a cycle number, then buffered in a FIFO. The FIFO is presented on a valid/ready stream to a logger or checker. It sits beside the processor top level and handles the halt-and-drain sequence so the consumer knows when the trace is complete.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
CNT_W, 32, width of instruction and cycle counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cm_valid  in  1  commit slot valid this cycle
cm_pc  in  16  PC of committing instruction
cm_regwrite  in  1  register file written
cm_wreg  in  3  destination register
cm_wdata  in  16  register write data
cm_memread  in  1  memory read
cm_memwrite  in  1  memory write
cm_memaddr  in  16  memory address
cm_memdata  in  16  memory store data
cm_halt  in  1  halt committing
rec_valid  out  1  head record available
rec_ready  in  1  consumer accepts head record
rec_type  out  3  0 NOP/branch, 1 REG, 2 LOAD, 3 STORE, 4 STU, 5 HALT
rec_inum  out  CNT_W  instruction number
rec_cycle  out  CNT_W  cycle stamp
rec_pc  out  16  PC
rec_reg  out  3  destination register
rec_regdata  out  16  register value
rec_addr  out  16  memory address
rec_memdata  out  16  store data
fifo_count  out  log2(DEPTH)+1  occupancy
overflow  out  1  sticky: a record was dropped
done  out  1  halt record consumed, FIFO empty

Behaviour:
- Reset (sync, high): all outputs 0; FIFO empty; inum_ctr=0; cycle_ctr=0; state=RUN; halt_pending=0. Reset mid-drain discards all content.
- cycle_ctr increments every non-reset cycle and wraps at 2^CNT_W. A record takes the value present at its sampling edge; the first post-reset cycle is stamped 0.
- Classification, by priority:
  - regwrite&memwrite -> STU
  - regwrite&memread -> LOAD
  - regwrite -> REG
  - halt -> HALT
  - memwrite -> STORE
  - else -> NOP
- Field zeroing by type:
  - rec_reg/rec_regdata are 0 unless REG/LOAD/STU.
  - rec_addr is 0 unless LOAD/STORE/STU.
  - rec_memdata is 0 unless STORE/STU.
- RUN, each cycle with cm_valid=1:
  - The record is stamped with inum = inum_ctr, then inum_ctr increments.
  - The counter increments even if the record is dropped, so gaps in inum expose drops.
  - The record is enqueued if the registered fifo_count < DEPTH. Fullness is judged before any same-cycle dequeue: a full FIFO rejects even when rec_ready=1.
  - If rejected, the record is dropped and overflow is set (cleared only by rst).
- HALT record:
  - Never dropped. If the FIFO is full, it is held in halt_pending and enqueued at the first cycle with space.
  - On the HALT commit cycle, state -> DRAIN.
- DRAIN:
  - cm_valid is ignored and inum_ctr is frozen.
  - halt_pending enqueues when space is available.
  - When fifo_count==0 and halt_pending==0, state -> DONE.
- DONE: done=1, rec_valid=0, all inputs ignored until rst.
- Latency: a commit at edge N appears at the FIFO head by edge N+1 when the FIFO was empty. Outputs are registered, show-ahead.
- Stream rules:
  - rec_valid = (count>0).
  - Transfer happens when rec_valid & rec_ready.
  - Head fields are stable while rec_valid=1 and no transfer occurs.
  - Simultaneous enqueue and dequeue at count>0 and <DEPTH leaves count unchanged.
- Pointers wrap modulo DEPTH. inum_ctr wraps at 2^CNT_W.

Test Plan:
- Reset, then commits REG(pc=0x0000,r3,0x1234), LOAD(pc=0x0002,r1,0xBEEF,addr 0x0040), STU(pc=0x0004,r2,0x0042,addr 0x0042,data 0x5555) with rec_ready=1 -> three records:
  - types 1,2,4; inums 0,1,2; cycles 0,1,2
  - unused fields zero
- STORE(addr 0x0010,data 0x00FF) then NOP(pc=0x0008) -> types 3,0; rec_reg=0, rec_regdata=0; NOP rec_addr=0, rec_memdata=0.
- rec_ready=0, 10 consecutive commits, DEPTH=8 -> fifo_count=8; overflow=1 after the 9th commit; release ready -> inums 0..7 delivered; next commit carries inum 10.
- FIFO full (ready=0), HALT commit, then 3 more commits -> halt_pending holds the HALT; later commits are ignored. Release ready -> 8 records, then HALT with inum 8; done=1 one cycle after the HALT transfer.
- Enqueue and dequeue every cycle with count=1 for 20 cycles -> count stays 1, pointers wrap correctly, inums contiguous.
- Assert rst during DRAIN with 4 records queued -> next cycle rec_valid=0, count=0, done=0, overflow=0; next commit gets inum 0, cycle 0.

Source files
------------

// File: rtl/commit_trace_packer.sv
// rtl/commit_trace_packer.sv - classifies commits into stamped trace records and streams them out of a FIFO
module commit_trace_packer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cm_valid,
    input  logic [15:0]              cm_pc,
    input  logic                     cm_regwrite,
    input  logic [2:0]               cm_wreg,
    input  logic [15:0]              cm_wdata,
    input  logic                     cm_memread,
    input  logic                     cm_memwrite,
    input  logic [15:0]              cm_memaddr,
    input  logic [15:0]              cm_memdata,
    input  logic                     cm_halt,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [2:0]               rec_type,
    output logic [CNT_W-1:0]         rec_inum,
    output logic [CNT_W-1:0]         rec_cycle,
    output logic [15:0]              rec_pc,
    output logic [2:0]               rec_reg,
    output logic [15:0]              rec_regdata,
    output logic [15:0]              rec_addr,
    output logic [15:0]              rec_memdata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] T_NOP   = 3'd0;
    localparam logic [2:0] T_REG   = 3'd1;
    localparam logic [2:0] T_LOAD  = 3'd2;
    localparam logic [2:0] T_STORE = 3'd3;
    localparam logic [2:0] T_STU   = 3'd4;
    localparam logic [2:0] T_HALT  = 3'd5;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef struct packed {
        logic [2:0]       ty;
        logic [CNT_W-1:0] inum;
        logic [CNT_W-1:0] cycle;
        logic [15:0]      pc;
        logic [2:0]       rg;
        logic [15:0]      regdata;
        logic [15:0]      addr;
        logic [15:0]      memdata;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             cm_rec;
    rec_t             halt_rec;
    rec_t             enq_rec;
    rec_t             head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] inum_ctr;
    logic [CNT_W-1:0] cycle_ctr;
    logic [1:0]       state;
    logic             halt_pending;
    logic             has_space;
    logic             enq;
    logic             deq;

    always_comb begin
        cm_rec = '0;
        if (cm_regwrite && cm_memwrite)     cm_rec.ty = T_STU;
        else if (cm_regwrite && cm_memread) cm_rec.ty = T_LOAD;
        else if (cm_regwrite)               cm_rec.ty = T_REG;
        else if (cm_halt)                   cm_rec.ty = T_HALT;
        else if (cm_memwrite)               cm_rec.ty = T_STORE;
        else                                cm_rec.ty = T_NOP;
        cm_rec.inum  = inum_ctr;
        cm_rec.cycle = cycle_ctr;
        cm_rec.pc    = cm_pc;
        if (cm_rec.ty == T_REG || cm_rec.ty == T_LOAD || cm_rec.ty == T_STU) begin
            cm_rec.rg      = cm_wreg;
            cm_rec.regdata = cm_wdata;
        end
        if (cm_rec.ty == T_LOAD || cm_rec.ty == T_STORE || cm_rec.ty == T_STU)
            cm_rec.addr = cm_memaddr;
        if (cm_rec.ty == T_STORE || cm_rec.ty == T_STU)
            cm_rec.memdata = cm_memdata;
    end

    // Fullness is judged on the registered count, before any same-cycle dequeue.
    assign has_space = (fifo_count != FULL_CNT);
    assign rec_valid = (fifo_count != '0);
    assign deq       = rec_valid && rec_ready;

    always_comb begin
        enq     = 1'b0;
        enq_rec = cm_rec;
        if (state == S_RUN && cm_valid && has_space) begin
            enq = 1'b1;
        end else if (state == S_DRAIN && halt_pending && has_space) begin
            enq     = 1'b1;
            enq_rec = halt_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            inum_ctr     <= '0;
            cycle_ctr    <= '0;
            state        <= S_RUN;
            halt_pending <= 1'b0;
            halt_rec     <= '0;
            overflow     <= 1'b0;
        end else begin
            cycle_ctr  <= cycle_ctr + CNT_W'(1);
            fifo_count <= fifo_count + (AW+1)'(enq) - (AW+1)'(deq);
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case (state)
                S_RUN: begin
                    if (cm_valid) begin
                        inum_ctr <= inum_ctr + CNT_W'(1);
                        if (cm_rec.ty == T_HALT) begin
                            state <= S_DRAIN;
                            // A halt is never dropped; park it until the FIFO has room.
                            if (!has_space) begin
                                halt_pending <= 1'b1;
                                halt_rec     <= cm_rec;
                            end
                        end else if (!has_space) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (halt_pending && has_space) halt_pending <= 1'b0;
                    if (fifo_count == '0 && !halt_pending) state <= S_DONE;
                end
                default: ;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign rec_type    = rec_valid ? head.ty      : '0;
    assign rec_inum    = rec_valid ? head.inum    : '0;
    assign rec_cycle   = rec_valid ? head.cycle   : '0;
    assign rec_pc      = rec_valid ? head.pc      : '0;
    assign rec_reg     = rec_valid ? head.rg      : '0;
    assign rec_regdata = rec_valid ? head.regdata : '0;
    assign rec_addr    = rec_valid ? head.addr    : '0;
    assign rec_memdata = rec_valid ? head.memdata : '0;
    assign done        = (state == S_DONE);
endmodule

// File: tb/tb_commit_trace_packer.sv
// tb/tb_commit_trace_packer.sv - randomized and directed bench against a queue-based trace model
module tb_commit_trace_packer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst, cm_valid, cm_regwrite, cm_memread, cm_memwrite, cm_halt, rec_ready;
    logic [15:0] cm_pc, cm_wdata, cm_memaddr, cm_memdata;
    logic [2:0] cm_wreg;
    logic rec_valid, overflow, done;
    logic [2:0] rec_type, rec_reg;
    logic [CNT_W-1:0] rec_inum, rec_cycle;
    logic [15:0] rec_pc, rec_regdata, rec_addr, rec_memdata;
    logic [3:0] fifo_count;

    commit_trace_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc),
        .cm_regwrite(cm_regwrite), .cm_wreg(cm_wreg), .cm_wdata(cm_wdata),
        .cm_memread(cm_memread), .cm_memwrite(cm_memwrite), .cm_memaddr(cm_memaddr),
        .cm_memdata(cm_memdata), .cm_halt(cm_halt), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_type(rec_type), .rec_inum(rec_inum),
        .rec_cycle(rec_cycle), .rec_pc(rec_pc), .rec_reg(rec_reg),
        .rec_regdata(rec_regdata), .rec_addr(rec_addr), .rec_memdata(rec_memdata),
        .fifo_count(fifo_count), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ty;
        logic [31:0] inum;
        logic [31:0] cyc;
        logic [15:0] pc;
        logic [2:0]  rg;
        logic [15:0] rd;
        logic [15:0] ad;
        logic [15:0] md;
    } rec_t;

    rec_t        m_q[$];
    rec_t        m_hrec;
    logic [31:0] m_inum, m_cycle;
    int          m_state;   // 0 run, 1 drain, 2 done
    bit          m_hp, m_ovf;
    int          tests_run = 0;
    int          tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic rw, mr, mw, h);
        if (rw && mw) return 4;
        if (rw && mr) return 2;
        if (rw)       return 1;
        if (h)        return 5;
        if (mw)       return 3;
        return 0;
    endfunction

    task automatic model_step();
        int   pre_size;
        bit   deq;
        rec_t r;
        if (rst) begin
            m_q.delete();
            m_inum = 0; m_cycle = 0; m_state = 0; m_hp = 0; m_ovf = 0;
            return;
        end
        pre_size = m_q.size();
        deq = (pre_size > 0) && rec_ready;
        if (deq) void'(m_q.pop_front());
        if (m_state == 0 && cm_valid) begin
            r.ty   = classify(cm_regwrite, cm_memread, cm_memwrite, cm_halt);
            r.inum = m_inum;
            r.cyc  = m_cycle;
            r.pc   = cm_pc;
            r.rg   = (r.ty == 1 || r.ty == 2 || r.ty == 4) ? cm_wreg : 3'd0;
            r.rd   = (r.ty == 1 || r.ty == 2 || r.ty == 4) ? cm_wdata : 16'd0;
            r.ad   = (r.ty == 2 || r.ty == 3 || r.ty == 4) ? cm_memaddr : 16'd0;
            r.md   = (r.ty == 3 || r.ty == 4) ? cm_memdata : 16'd0;
            m_inum++;
            if (pre_size < DEPTH) m_q.push_back(r);
            else if (r.ty == 5) begin m_hp = 1; m_hrec = r; end
            else m_ovf = 1;
            if (r.ty == 5) m_state = 1;
        end else if (m_state == 1) begin
            if (pre_size == 0 && !m_hp) m_state = 2;
            else if (m_hp && pre_size < DEPTH) begin m_q.push_back(m_hrec); m_hp = 0; end
        end
        m_cycle++;
    endtask

    task automatic compare();
        rec_t e;
        e = '{0, 0, 0, 0, 0, 0, 0, 0};
        if (m_q.size() > 0) e = m_q[0];
        check_eq("rec_valid", rec_valid, m_q.size() > 0);
        check_eq("fifo_count", fifo_count, m_q.size());
        check_eq("overflow", overflow, m_ovf);
        check_eq("done", done, m_state == 2);
        check_eq("rec_type", rec_type, e.ty);
        check_eq("rec_inum", rec_inum, e.inum);
        check_eq("rec_cycle", rec_cycle, e.cyc);
        check_eq("rec_pc", rec_pc, e.pc);
        check_eq("rec_reg", rec_reg, e.rg);
        check_eq("rec_regdata", rec_regdata, e.rd);
        check_eq("rec_addr", rec_addr, e.ad);
        check_eq("rec_memdata", rec_memdata, e.md);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_in(input logic v, rw, mr, mw, h, input logic [15:0] pc,
                          input logic [2:0] wr, input logic [15:0] wd, ma, md);
        cm_valid = v; cm_regwrite = rw; cm_memread = mr; cm_memwrite = mw; cm_halt = h;
        cm_pc = pc; cm_wreg = wr; cm_wdata = wd; cm_memaddr = ma; cm_memdata = md;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int done_cycles;

    initial begin
        rec_ready = 1'b1;
        do_reset();

        // Basic classification and stamping
        set_in(1, 1, 0, 0, 0, 16'h0000, 3'd3, 16'h1234, 16'h0000, 16'h0000); step();
        check_eq("first_type", rec_type, 1);
        check_eq("first_cycle", rec_cycle, 0);
        set_in(1, 1, 1, 0, 0, 16'h0002, 3'd1, 16'hBEEF, 16'h0040, 16'h0000); step();
        check_eq("load_type", rec_type, 2);
        set_in(1, 1, 0, 1, 0, 16'h0004, 3'd2, 16'h0042, 16'h0042, 16'h5555); step();
        check_eq("stu_inum", rec_inum, 2);
        set_in(1, 0, 0, 1, 0, 16'h0006, 3'd5, 16'h7777, 16'h0010, 16'h00FF); step();
        set_in(1, 0, 0, 0, 0, 16'h0008, 3'd6, 16'h9999, 16'hAAAA, 16'hBBBB); step();
        idle(); step(); step();

        // Overflow: 10 commits into a stalled 8-entry FIFO
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(1, 1, 0, 0, 0, 16'(2 * i), 3'(i), 16'($urandom), 16'h0, 16'h0); step();
            if (i == 7) check_eq("ovf_before_9th", overflow, 0);
            if (i == 8) check_eq("ovf_after_9th", overflow, 1);
        end
        check_eq("full_count", fifo_count, 8);
        idle(); rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        set_in(1, 1, 0, 0, 0, 16'h0100, 3'd1, 16'h1, 16'h0, 16'h0); step();
        check_eq("gap_inum", rec_inum, 10);
        idle(); step();

        // Halt with a full FIFO is held, later commits ignored
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(1, 1, 0, 0, 0, 16'(2 * i), 3'd4, 16'($urandom), 16'h0, 16'h0); step();
        end
        set_in(1, 0, 0, 0, 1, 16'h0010, 3'd0, 16'h0, 16'h0, 16'h0); step();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, 0, 16'h0020, 3'd1, 16'h5, 16'h0, 16'h0); step();
        end
        idle(); rec_ready = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check_eq("done_at_halt_xfer", done, 0);
        step();
        check_eq("done_after_halt", done, 1);
        step();

        // Sustained enqueue/dequeue at count 1
        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(1, 1, 0, 0, 0, 16'(i), 3'(i), 16'($urandom), 16'h0, 16'h0); step();
        end
        check_eq("steady_count", fifo_count, 1);
        idle(); step();

        // Reset during drain
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, 0, 16'(i), 3'd2, 16'h3, 16'h0, 16'h0); step();
        end
        set_in(1, 0, 0, 0, 1, 16'h0030, 3'd0, 16'h0, 16'h0, 16'h0); step();
        check_eq("drain_count", fifo_count, 4);
        idle(); rst = 1'b1; step(); rst = 1'b0;
        check_eq("rst_drain_valid", rec_valid, 0);
        set_in(1, 1, 0, 0, 0, 16'h0040, 3'd7, 16'h8, 16'h0, 16'h0); step();
        check_eq("post_rst_inum", rec_inum, 0);
        check_eq("post_rst_cycle", rec_cycle, 0);

        // Randomized traffic
        rec_ready = 1'b1;
        do_reset();
        done_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 10) < 7, $urandom % 2, $urandom % 2, $urandom % 2,
                   ($urandom % 30) == 0, 16'($urandom), 3'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom));
            rec_ready = ($urandom % 10) < 6;
            done_cycles = (m_state == 2) ? done_cycles + 1 : 0;
            rst = (done_cycles > 3) || (($urandom % 400) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
